sound_i2s_tx: RTL and testbench

//  I2S stereo transmitter for the audio DAC, clocked by the 12.288 MHz audio clock from the core PLL.

---
 rtl/sound_i2s_tx.sv | 145 ++++++++++++++
 tb/tb_sound_i2s_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_i2s_tx.sv
// sound_i2s_tx -- I2S stereo transmitter for the audio DAC.
//
// Takes L/R sample pairs over a valid/ready handshake, holds one pair in a
// pending register and one in the frame register that feeds the serialiser.
// Each pair is sent as a 64-bit I2S frame (two 32-bit slots, MSB first,
// zero-padded). The block also generates the bit clock and word select.
//
// Parameters:
//   DATA_WIDTH  sample width per channel (1..31)
//   DIV_LOG2    log2(clk cycles per audio_sclk period), must be >= 1
//
// Ports:
//   clk           audio clock (12.288 MHz nominal)
//   reset         synchronous, active-high
//   sample_l      left sample, two's complement
//   sample_r      right sample, two's complement
//   sample_valid  pair on sample_l/sample_r is valid
//   sample_ready  pending buffer empty; a pair transfers when valid && ready
//   audio_sclk    bit clock, 50% duty
//   audio_lrck    word select: 0 = left slot, 1 = right slot
//   audio_dac     serial data, changes on the sclk falling edge
//   underrun      1-clk pulse on the last cycle of a frame when no pair is pending
//
// Build option:
//   I2S_UNDERRUN_MUTE_EN  when defined, an underrun frame transmits zeros
//                         (frame register cleared); otherwise it repeats the
//                         last loaded pair.

module sound_i2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int DIV_LOG2   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample_l,
   input  logic [DATA_WIDTH-1:0] sample_r,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  audio_sclk,
   output logic                  audio_lrck,
   output logic                  audio_dac,
   output logic                  underrun
);

   localparam int CW  = 6 + DIV_LOG2;
   localparam int PAD = 32 - DATA_WIDTH;

   logic [CW-1:0]         r_cnt;
   logic                  r_pendFull;
   logic [DATA_WIDTH-1:0] r_pendL;
   logic [DATA_WIDTH-1:0] r_pendR;
   logic [DATA_WIDTH-1:0] r_frameL;
   logic [DATA_WIDTH-1:0] r_frameR;

   logic [CW-1:0]         w_cntNext;
   logic                  w_boundary;
   logic                  w_accept;
   logic                  w_pendFullNext;
   logic [DATA_WIDTH-1:0] w_frameLNext;
   logic [DATA_WIDTH-1:0] w_frameRNext;
   logic [5:0]            w_bitNext;
   logic [31:0]           w_slotL;
   logic [31:0]           w_slotR;
   logic                  w_dacNext;
   logic                  w_sclkNext;
   logic                  w_lrckNext;
   logic                  w_underrunNext;

   // Buffer management: the last cycle of a frame (cnt all-ones) hands the
   // pending pair to the frame register. An accept can never coincide with
   // that load because ready is low whenever a pair is pending.
   always_comb begin
      w_cntNext      = r_cnt + {{(CW-1){1'b0}}, 1'b1};
      w_boundary     = &r_cnt;
      w_accept       = sample_valid && !r_pendFull;
      w_pendFullNext = r_pendFull;
      w_frameLNext   = r_frameL;
      w_frameRNext   = r_frameR;
      if (w_boundary) begin
         if (r_pendFull) begin
            w_pendFullNext = 1'b0;
            w_frameLNext   = r_pendL;
            w_frameRNext   = r_pendR;
         end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
            w_frameLNext   = '0;
            w_frameRNext   = '0;
`else
            w_frameLNext   = r_frameL;
            w_frameRNext   = r_frameR;
`endif
         end
      end
      if (w_accept) begin
         w_pendFullNext = 1'b1;
      end
   end

   // Output decode from the upcoming counter value, so every output is a flop
   // that lines up with the cnt it belongs to. Each slot is the sample padded
   // to 32 bits; bit b of the slot is sent MSB first, hence index 31-b (~b).
   // lrck leads each slot's MSB by one bit time.
   always_comb begin
      w_bitNext      = w_cntNext[CW-1:DIV_LOG2];
      w_slotL        = {w_frameLNext, {PAD{1'b0}}};
      w_slotR        = {w_frameRNext, {PAD{1'b0}}};
      w_dacNext      = w_bitNext[5] ? w_slotR[~w_bitNext[4:0]] : w_slotL[~w_bitNext[4:0]];
      w_sclkNext     = w_cntNext[DIV_LOG2-1];
      w_lrckNext     = (w_bitNext >= 6'd31) && (w_bitNext <= 6'd62);
      w_underrunNext = (&w_cntNext) && !w_pendFullNext;
   end

   // State and output registers. Reset leaves ready high so a pair can be
   // accepted on the very first cycle after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_pendFull   <= 1'b0;
         r_pendL      <= '0;
         r_pendR      <= '0;
         r_frameL     <= '0;
         r_frameR     <= '0;
         sample_ready <= 1'b1;
         audio_sclk   <= 1'b0;
         audio_lrck   <= 1'b0;
         audio_dac    <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         r_cnt        <= w_cntNext;
         r_pendFull   <= w_pendFullNext;
         if (w_accept) begin
            r_pendL   <= sample_l;
            r_pendR   <= sample_r;
         end
         r_frameL     <= w_frameLNext;
         r_frameR     <= w_frameRNext;
         sample_ready <= !w_pendFullNext;
         audio_sclk   <= w_sclkNext;
         audio_lrck   <= w_lrckNext;
         audio_dac    <= w_dacNext;
         underrun     <= w_underrunNext;
      end
   end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Testbench for sound_i2s_tx with default parameters (16-bit samples,
// 4 clk per bit, 256 clk per frame).

module tb_sound_i2s_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sampleL = 16'h0;
   logic [15:0] sampleR = 16'h0;
   logic        sampleValid = 1'b0;
   logic        sampleReady;
   logic        audioSclk;
   logic        audioLrck;
   logic        audioDac;
   logic        underrun;

   int checks = 0;
   int failures = 0;

   // Reference model state: position in frame, pending slot, frame word.
   int          mPos = 0;
   bit          mValid = 1'b0;
   bit          mPend = 1'b0;
   logic [15:0] mPendL = 16'h0;
   logic [15:0] mPendR = 16'h0;
   logic [15:0] mFrameL = 16'h0;
   logic [15:0] mFrameR = 16'h0;

   int accCount = 0;
   int accBadPos = 0;
   int urCount = 0;

   sound_i2s_tx #(.DATA_WIDTH(16), .DIV_LOG2(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_l     (sampleL),
      .sample_r     (sampleR),
      .sample_valid (sampleValid),
      .sample_ready (sampleReady),
      .audio_sclk   (audioSclk),
      .audio_lrck   (audioLrck),
      .audio_dac    (audioDac),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at t=%0t pos=%0d: got %h, expected %h", name, $time, mPos, actual, expected);
      end
   endtask

   // Model update at each active edge; also observes handshakes and underrun
   // pulses of the cycle that is ending.
   always @(posedge clk) begin
      bit acc;
      if (mValid) begin
         if (sampleValid && sampleReady === 1'b1) begin
            accCount++;
            if (mPos != 0) accBadPos++;
         end
         if (underrun === 1'b1) urCount++;
      end
      if (reset) begin
         mValid  = 1'b1;
         mPos    = 0;
         mPend   = 1'b0;
         mFrameL = 16'h0;
         mFrameR = 16'h0;
      end else begin
         acc = sampleValid && !mPend;
         if (mPos == 255) begin
            if (mPend) begin
               mFrameL = mPendL;
               mFrameR = mPendR;
               mPend   = 1'b0;
            end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
               mFrameL = 16'h0;
               mFrameR = 16'h0;
`endif
            end
         end
         if (acc) begin
            mPend  = 1'b1;
            mPendL = sampleL;
            mPendR = sampleR;
         end
         mPos = (mPos + 1) % 256;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [63:0] word;
      int          b;
      if (mValid) begin
         b    = mPos / 4;
         word = {mFrameL, 16'h0000, mFrameR, 16'h0000};
         checkOutput("sclk", 64'(audioSclk), 64'((mPos % 4) >= 2));
         checkOutput("lrck", 64'(audioLrck), 64'(b >= 31 && b <= 62));
         checkOutput("dac", 64'(audioDac), 64'(word[63 - b]));
         checkOutput("ready", 64'(sampleReady), 64'(!mPend));
         checkOutput("underrun", 64'(underrun), 64'(mPos == 255 && !mPend));
      end
   end

   task automatic gotoPos(input int target);
      int n = 0;
      while (mPos != target && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (mPos != target) begin
         checks++;
         failures++;
         $display("[TB] FAIL gotoPos: got pos %0d, expected %0d", mPos, target);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
      sampleL     = l;
      sampleR     = r;
      sampleValid = 1'b1;
      @(negedge clk);
      sampleValid = 1'b0;
   endtask

   // Starts at pos 0; samples each bit mid-way through its sclk-high half.
   task automatic captureFrame(output logic [63:0] w);
      w = 64'h0;
      for (int c = 0; c < 256; c++) begin
         if (c % 4 == 2) w[63 - c / 4] = audioDac;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [63:0] w;
      int ur0;
      int acc0;
      int bad0;

      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: sclk, lrck timing, no data, underruns at 255 and 511.
      ur0 = urCount;
      checkOutput("rst_ready", 64'(sampleReady), 64'd1);
      checkOutput("rst_dac", 64'(audioDac), 64'd0);
      checkOutput("rst_underrun", 64'(underrun), 64'd0);
      gotoPos(2);
      checkOutput("sclk_high_p2", 64'(audioSclk), 64'd1);
      gotoPos(123);
      checkOutput("lrck_123", 64'(audioLrck), 64'd0);
      gotoPos(124);
      checkOutput("lrck_124", 64'(audioLrck), 64'd1);
      gotoPos(251);
      checkOutput("lrck_251", 64'(audioLrck), 64'd1);
      gotoPos(252);
      checkOutput("lrck_252", 64'(audioLrck), 64'd0);
      gotoPos(254);
      checkOutput("no_ur_frame0", 64'(urCount - ur0), 64'd0);
      gotoPos(255);
      checkOutput("underrun_255", 64'(underrun), 64'd1);
      gotoPos(0);
      gotoPos(255);
      checkOutput("underrun_511", 64'(underrun), 64'd1);
      gotoPos(0);
      checkOutput("idle_ur_count", 64'(urCount - ur0), 64'd2);

      // Single pair, transmitted in the following frame.
      gotoPos(10);
      applyStimulus(16'hA5C3, 16'h8001);
      gotoPos(0);
      captureFrame(w);
      checkOutput("frame_a5c3", w, {16'hA5C3, 16'h0000, 16'h8001, 16'h0000});

      // Continuous valid for three frames: one accept per frame at pos 0.
      ur0  = urCount;
      acc0 = accCount;
      bad0 = accBadPos;
      sampleValid = 1'b1;
      for (int f = 0; f < 3; f++) begin
         sampleL = 16'h1000 + 16'(f);
         sampleR = 16'h2000 + 16'(f);
         repeat (256) @(negedge clk);
      end
      sampleValid = 1'b0;
      checkOutput("stream_accepts", 64'(accCount - acc0), 64'd3);
      checkOutput("stream_accept_pos", 64'(accBadPos - bad0), 64'd0);
      checkOutput("stream_underruns", 64'(urCount - ur0), 64'd0);

      // First valid exactly at the boundary with pending empty.
      gotoPos(255);
      checkOutput("late_underrun", 64'(underrun), 64'd1);
      sampleL     = 16'h1111;
      sampleR     = 16'h2222;
      sampleValid = 1'b1;
      @(negedge clk);
      sampleValid = 1'b0;
      checkOutput("late_accepted", 64'(sampleReady), 64'd0);
      captureFrame(w);
`ifdef I2S_UNDERRUN_MUTE_EN
      checkOutput("late_ur_frame", w, 64'h0);
`else
      checkOutput("late_ur_frame", w, {16'h1002, 16'h0000, 16'h2002, 16'h0000});
`endif
      captureFrame(w);
      checkOutput("late_pair_frame", w, {16'h1111, 16'h0000, 16'h2222, 16'h0000});

      // Load one pair then stop sending.
      gotoPos(10);
      applyStimulus(16'h1234, 16'h0000);
      gotoPos(0);
      captureFrame(w);
      checkOutput("frame_1234", w, {16'h1234, 16'h0000, 16'h0000, 16'h0000});
      captureFrame(w);
`ifdef I2S_UNDERRUN_MUTE_EN
      checkOutput("repeat_1234", w, 64'h0);
`else
      checkOutput("repeat_1234", w, {16'h1234, 16'h0000, 16'h0000, 16'h0000});
`endif

      // Reset mid-serialisation with a pair pending.
      gotoPos(50);
      applyStimulus(16'hDEAD, 16'hBEEF);
      gotoPos(100);
      checkOutput("pre_reset_ready", 64'(sampleReady), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_sclk", 64'(audioSclk), 64'd0);
      checkOutput("mid_rst_lrck", 64'(audioLrck), 64'd0);
      checkOutput("mid_rst_dac", 64'(audioDac), 64'd0);
      checkOutput("mid_rst_underrun", 64'(underrun), 64'd0);
      checkOutput("mid_rst_ready", 64'(sampleReady), 64'd1);
      reset = 1'b0;
      gotoPos(1);
      gotoPos(0);
      captureFrame(w);
      checkOutput("discarded_pair", w, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
